// File: rtl/reg_bank_32x32_if.sv
// Register-file port bundle: one write port (WE3/A3/WD3), two read ports (A1/RD1, A2/RD2).
interface reg_bank_32x32_if #(
  parameter int XLEN = 32
);
  logic            WE3;
  logic [4:0]      A1;
  logic [4:0]      A2;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;

  modport master (
    output WE3, A1, A2, A3, WD3,
    input  RD1, RD2
  );

  modport slave (
    input  WE3, A1, A2, A3, WD3,
    output RD1, RD2
  );
endinterface

// File: rtl/reg_bank_32x32.sv
// RISC-V style integer register file: 32 x XLEN, two combinational read ports,
// one synchronous write port. x0 is hard-wired to zero. Reset clears every
// register and wins over a simultaneous write. No write-to-read bypass: a
// register written on an edge shows its new value only after that edge.
module reg_bank_32x32 #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic             clk,
  input logic             rst,
  reg_bank_32x32_if.slave bus
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage update: reset clears all entries, otherwise a write to a nonzero address lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.WE3 && (bus.A3 != 5'd0)) begin
      regs[bus.A3] <= bus.WD3;
    end
  end

  // Read port 1: purely combinational, x0 forced to zero regardless of storage.
  always_comb begin
    bus.RD1 = '0;
    if (bus.A1 != 5'd0) begin
      bus.RD1 = regs[bus.A1];
    end
  end

  // Read port 2: same as port 1, fully independent decode.
  always_comb begin
    bus.RD2 = '0;
    if (bus.A2 != 5'd0) begin
      bus.RD2 = regs[bus.A2];
    end
  end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Directed bench for reg_bank_32x32. Expected read data is queued when the
// read addresses are driven and popped when the outputs are sampled.
module tb_reg_bank_32x32;

  logic clk;
  logic rst;

  reg_bank_32x32_if #(.XLEN(32)) bus ();

  reg_bank_32x32 #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  // Pop one expected value and compare against an observed read port.
  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Drive both read addresses, queue expectations, sample 1 ns later (no edge).
  task automatic expect_rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
    bus.A1 = a1;
    bus.A2 = a2;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    #1;
    compare({tag, "_rd1"}, bus.RD1);
    compare({tag, "_rd2"}, bus.RD2);
  endtask

  // One write on the next rising edge, then write enable drops.
  task automatic wr(input logic [4:0] a3, input logic [31:0] wd);
    @(negedge clk);
    bus.WE3 = 1'b1;
    bus.A3  = a3;
    bus.WD3 = wd;
    @(posedge clk);
    #1;
    bus.WE3 = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bus.WE3 = 1'b0;
    bus.A1  = 5'd0;
    bus.A2  = 5'd0;
    bus.A3  = 5'd0;
    bus.WD3 = '0;

    // Reset: every address reads zero on both ports.
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_rd("reset_all", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    // Three back-to-back writes.
    wr(5'd3, 32'hAAAA1111);
    wr(5'd5, 32'h12345678);
    wr(5'd7, 32'hDEADBEEF);
    @(negedge clk);
    expect_rd("rd_3_5", 5'd3, 5'd5, 32'hAAAA1111, 32'h12345678);
    expect_rd("rd_7_3", 5'd7, 5'd3, 32'hDEADBEEF, 32'hAAAA1111);
    expect_rd("rd_5_7", 5'd5, 5'd7, 32'h12345678, 32'hDEADBEEF);
    expect_rd("same_reg", 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);

    // Write to x0 is ignored.
    wr(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    expect_rd("x0_write", 5'd0, 5'd3, 32'h0, 32'hAAAA1111);

    // WE3=0 leaves storage untouched.
    @(negedge clk);
    bus.WE3 = 1'b0;
    bus.A3  = 5'd5;
    bus.WD3 = 32'h0BADF00D;
    @(posedge clk);
    #1;
    expect_rd("we_low", 5'd5, 5'd3, 32'h12345678, 32'hAAAA1111);

    // No bypass: old value before the edge, new value after.
    @(negedge clk);
    bus.WE3 = 1'b1;
    bus.A3  = 5'd9;
    bus.WD3 = 32'hCAFEBABE;
    expect_rd("pre_edge", 5'd9, 5'd9, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    bus.WE3 = 1'b0;
    expect_rd("post_edge", 5'd9, 5'd5, 32'hCAFEBABE, 32'h12345678);

    // Back-to-back writes to one register keep the last value.
    wr(5'd10, 32'h00000001);
    wr(5'd10, 32'h00000002);
    wr(5'd31, 32'h5A5A5A5A);
    @(negedge clk);
    expect_rd("b2b_same", 5'd10, 5'd31, 32'h00000002, 32'h5A5A5A5A);

    // Reset beats a simultaneous write and discards earlier contents.
    @(negedge clk);
    rst     = 1'b1;
    bus.WE3 = 1'b1;
    bus.A3  = 5'd3;
    bus.WD3 = 32'h11111111;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.WE3 = 1'b0;
    expect_rd("rst_mid_3_7", 5'd3, 5'd7, 32'h0, 32'h0);
    expect_rd("rst_mid_9_31", 5'd9, 5'd31, 32'h0, 32'h0);

    // Writes resume right after reset.
    wr(5'd3, 32'h13579BDF);
    @(negedge clk);
    expect_rd("post_rst_wr", 5'd3, 5'd5, 32'h13579BDF, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
